// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART TX scheduler.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN (busy-rise timeout).
package uart_tx_sched_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_WIDE_BYTES   = 2;
  localparam int DEF_BUSY_TIMEOUT = 4;

  // Byte counter must hold WIDE_BYTES itself.
  localparam int BYTE_CNT_W = $clog2(DEF_WIDE_BYTES + 1);

  // Timeout counter width.
  localparam int TO_W = 3;

  // Requester ids, also the bit positions in the arbiter req/grant vectors.
  localparam logic REQ_RF  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } sched_state_t;

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-way round-robin arbiter. The grant is combinational; the pointer
// moves to the losing side after every grant so a tie alternates.
module uart_tx_rr_arb
  import uart_tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic ptr;

  // Pick the single requester, or the pointer side on a tie.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        grant = (ptr == REQ_ALU) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  // Point at the loser of the grant just given; RF wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_RF;
    end else if (grant != 2'b00) begin
      ptr <= grant[REQ_RF] ? REQ_ALU : REQ_RF;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules the shared UART_TX serializer between the reg-file byte path
// and the ALU word path (LSB byte first). Each frame is loaded with a
// one-cycle strobe and then sequenced off the rise and fall of TX_BUSY.
// Handshake: a requester holds VALID with stable data; a transfer happens
// in the cycle where VALID and READY are both high. READY is only ever
// high while IDLE with TX_BUSY low, and only for the arbitration winner.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN. When defined, a load
// that never sees TX_BUSY rise is abandoned after BUSY_TIMEOUT full
// WAIT_HI cycles with a one-cycle TX_TIMEOUT pulse; otherwise WAIT_HI
// waits indefinitely and TX_TIMEOUT is tied low.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WIDE_BYTES = DEF_WIDE_BYTES
`ifdef UART_TX_SCHED_TIMEOUT_EN
  ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
`endif
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             RF_VALID,
  input  logic [DATA_WIDTH-1:0]            RF_DATA,
  output logic                             RF_READY,
  input  logic                             ALU_VALID,
  input  logic [DATA_WIDTH*WIDE_BYTES-1:0] ALU_DATA,
  output logic                             ALU_READY,
  input  logic                             TX_BUSY,
  output logic [DATA_WIDTH-1:0]            TX_P_DATA,
  output logic                             TX_DATA_VALID,
  output logic                             SCHED_BUSY,
  output logic                             TX_TIMEOUT,
  output sched_state_t                     DBG_STATE
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH * WIDE_BYTES;

  sched_state_t          state;
  logic [AW-1:0]         hold;
  logic [BYTE_CNT_W-1:0] cnt;
  logic [DW-1:0]         p_data_q;
  logic                  dv_q;
  logic [1:0]            grant;
  logic                  arb_en;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [TO_W-1:0]       to_cnt;
  logic                  timeout_q;
`endif

  // Arbitrate only while idle and the serializer is free; never in reset.
  assign arb_en = (state == IDLE) && !TX_BUSY && !RST;

  uart_tx_rr_arb u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req    ({ALU_VALID, RF_VALID}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign RF_READY      = grant[REQ_RF];
  assign ALU_READY     = grant[REQ_ALU];
  assign TX_P_DATA     = p_data_q;
  assign TX_DATA_VALID = dv_q;
  assign SCHED_BUSY    = (state != IDLE);
  assign DBG_STATE     = state;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign TX_TIMEOUT = timeout_q;
`else
  assign TX_TIMEOUT = 1'b0;
`endif

  // Scheduler FSM with hold shift register, byte counter and output regs.
  // The load strobe and byte are registered on entry to LOAD, so the
  // strobe appears the cycle after the handshake and the byte stays put
  // until the next load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold     <= '0;
      cnt      <= '0;
      p_data_q <= '0;
      dv_q     <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant[REQ_ALU]) begin
            hold     <= ALU_DATA;
            cnt      <= BYTE_CNT_W'(WIDE_BYTES);
            p_data_q <= ALU_DATA[DW-1:0];
            dv_q     <= 1'b1;
            state    <= LOAD;
          end else if (grant[REQ_RF]) begin
            hold     <= {{(AW-DW){1'b0}}, RF_DATA};
            cnt      <= BYTE_CNT_W'(1);
            p_data_q <= RF_DATA;
            dv_q     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (TX_BUSY) begin
            state <= WAIT_LO;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          // Abandon the word: remaining bytes are dropped.
          else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            cnt       <= '0;
            hold      <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_LO: begin
          if (!TX_BUSY) begin
            cnt  <= cnt - 1'b1;
            hold <= hold >> DW;
            if (cnt > BYTE_CNT_W'(1)) begin
              p_data_q <= hold[2*DW-1:DW];
              dv_q     <= 1'b1;
              state    <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
